// File: rtl/cordic_pipe_param_if.sv
// Sample-in / result-out bundle for the CORDIC pipeline.
// The slave modport is the engine side and the master modport is the source/sink side.
interface cordic_pipe_param_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_mode;
  logic signed [W-1:0]  in_x;
  logic signed [W-1:0]  in_y;
  logic signed [W-1:0]  in_z;
  logic [TAG_W-1:0]     in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic signed [W+1:0]  out_x;
  logic signed [W+1:0]  out_y;
  logic signed [W-1:0]  out_z;
  logic                 out_mode;
  logic [TAG_W-1:0]     out_tag;

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, out_mode, out_tag
  );

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, in_tag, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, out_mode, out_tag
  );
endinterface

// File: rtl/cordic_pipe_param.sv
// Fully pipelined CORDIC. Each sample selects rotation or vectoring mode.
// A pi pre-rotation stage extends the range to the full circle. Every stage stalls together under backpressure.
module cordic_pipe_param #(
  parameter int unsigned W      = 16,
  parameter int unsigned STAGES = 16,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cordic_pipe_param_if.slave   io
);

  localparam int unsigned XW    = W + 2;
  localparam real         PI    = 3.14159265358979323846;
  localparam logic [W-1:0] ZFLIP = {1'b1, {(W-1){1'b0}}};

  // atan(2^-k) in BAM units, rounded; power series is exact enough for t <= 0.5
  function automatic logic signed [W-1:0] atan_bam(input int k);
    real t;
    real p;
    real s;
    t = 1.0;
    p = 0.0;
    s = 0.0;
    if (k == 0) begin
      s = PI / 4.0;
    end else begin
      for (int i = 0; i < k; i++) t = t / 2.0;
      p = t;
      for (int n = 0; n < 64; n++) begin
        if ((n % 2) == 0) s = s + p / real'(2 * n + 1);
        else              s = s - p / real'(2 * n + 1);
        p = p * t * t;
      end
    end
    return W'($rtoi(s / PI * (2.0 ** (W - 1)) + 0.5));
  endfunction

  logic en_c;

  logic                 v0_q, v0_d, m0_q, m0_d;
  logic [TAG_W-1:0]     t0_q, t0_d;
  logic signed [XW-1:0] x0_q, x0_d, y0_q, y0_d;
  logic signed [W-1:0]  z0_q, z0_d;

  // Pre-rotation by pi so the micro-rotations only need to cover +-pi/2
  always_comb begin
    logic signed [XW-1:0] xe;
    logic signed [XW-1:0] ye;
    logic                 flip;
    xe   = XW'(io.in_x);
    ye   = XW'(io.in_y);
    flip = io.in_mode ? io.in_x[W-1] : (io.in_z[W-1] ^ io.in_z[W-2]);
    v0_d = io.in_valid;
    m0_d = io.in_mode;
    t0_d = io.in_tag;
    x0_d = flip ? -xe : xe;
    y0_d = flip ? -ye : ye;
    z0_d = flip ? (io.in_z ^ ZFLIP) : io.in_z;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v0_q <= 1'b0;
      m0_q <= 1'b0;
      t0_q <= '0;
      x0_q <= '0;
      y0_q <= '0;
      z0_q <= '0;
    end else if (en_c) begin
      v0_q <= v0_d;
      m0_q <= m0_d;
      t0_q <= t0_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      z0_q <= z0_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam logic signed [W-1:0] ANG = atan_bam(k);

    logic                 vp, mp;
    logic [TAG_W-1:0]     tp;
    logic signed [XW-1:0] xp, yp;
    logic signed [W-1:0]  zp;

    logic                 v_q, v_d, m_q, m_d;
    logic [TAG_W-1:0]     t_q, t_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic signed [W-1:0]  z_q, z_d;

    if (k == 0) begin : g_src
      assign vp = v0_q;
      assign mp = m0_q;
      assign tp = t0_q;
      assign xp = x0_q;
      assign yp = y0_q;
      assign zp = z0_q;
    end else begin : g_src
      assign vp = g_stg[k-1].v_q;
      assign mp = g_stg[k-1].m_q;
      assign tp = g_stg[k-1].t_q;
      assign xp = g_stg[k-1].x_q;
      assign yp = g_stg[k-1].y_q;
      assign zp = g_stg[k-1].z_q;
    end

    // Rotation steers z to zero; vectoring steers y to zero
    always_comb begin
      logic dir;
      dir = mp ? ~yp[XW-1] : zp[W-1];
      v_d = vp;
      m_d = mp;
      t_d = tp;
      if (!dir) begin
        x_d = xp - (yp >>> k);
        y_d = yp + (xp >>> k);
        z_d = zp - ANG;
      end else begin
        x_d = xp + (yp >>> k);
        y_d = yp - (xp >>> k);
        z_d = zp + ANG;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        m_q <= 1'b0;
        t_q <= '0;
        x_q <= '0;
        y_q <= '0;
        z_q <= '0;
      end else if (en_c) begin
        v_q <= v_d;
        m_q <= m_d;
        t_q <= t_d;
        x_q <= x_d;
        y_q <= y_d;
        z_q <= z_d;
      end
    end
  end

  assign en_c        = !g_stg[STAGES-1].v_q || io.out_ready;
  assign io.in_ready = en_c;

  assign io.out_valid = g_stg[STAGES-1].v_q;
  assign io.out_mode  = g_stg[STAGES-1].m_q;
  assign io.out_tag   = g_stg[STAGES-1].t_q;
  assign io.out_x     = g_stg[STAGES-1].x_q;
  assign io.out_y     = g_stg[STAGES-1].y_q;
  assign io.out_z     = g_stg[STAGES-1].z_q;

endmodule

// File: tb/tb_cordic_pipe_param.sv
// Scoreboard bench for cordic_pipe_param. A driver queues hand-computed expectations.
// A negedge monitor checks each accepted result in order.
module tb_cordic_pipe_param;
  localparam int unsigned W      = 16;
  localparam int unsigned STAGES = 16;
  localparam int unsigned TAG_W  = 4;
  localparam int          LAT    = STAGES + 1;
  localparam int          TOL_XY = STAGES / 2 + 2;
  localparam int          TOL_Z  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_pipe_param_if #(.W(W), .TAG_W(TAG_W)) bus();

  cordic_pipe_param #(.W(W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    bit               mode;
    logic [TAG_W-1:0] tag;
    int               ex, ey, ez;
    int               lat;
    bit               consec;
    int               in_cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   last_out = -100;

  // Rotation vectors: x = 9949 (unit after gain), y = 0
  int rot_z  [4] = '{32'h2000, 32'h8000, 32'h6000, 0};
  int rot_ex [4] = '{11585, -16384, -11585, 16384};
  int rot_ey [4] = '{11585, 0, 11585, 0};
  // Vectoring vectors: magnitude 5000 -> 8234 after gain
  int vec_x  [4] = '{3000, -3000, 0, 3000};
  int vec_y  [4] = '{4000, 4000, 5000, -4000};
  int vec_ez [4] = '{9672, 23096, 16384, -9672};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, bit ok, int act, int expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endfunction

  function automatic bit near(int a, int b, int tol);
    return ((a - b) <= tol) && ((b - a) <= tol);
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    int   ocyc;
    logic signed [W-1:0] dz;
    if (!rst && bus.out_valid && bus.out_ready) begin
      ocyc = cyc + 1;
      if (sb.size() == 0) begin
        check("spurious_out", 1'b0, int'(bus.out_tag), -1);
      end else begin
        e  = sb.pop_front();
        dz = W'(int'(bus.out_z) - e.ez);
        check("out_mode", bus.out_mode == e.mode, int'(bus.out_mode), int'(e.mode));
        check("out_tag", bus.out_tag == e.tag, int'(bus.out_tag), int'(e.tag));
        check("out_x", near(int'(bus.out_x), e.ex, TOL_XY), int'(bus.out_x), e.ex);
        check("out_y", near(int'(bus.out_y), e.ey, TOL_XY), int'(bus.out_y), e.ey);
        check("out_z", near(int'(dz), 0, TOL_Z), int'(bus.out_z), e.ez);
        if (e.lat > 0) check("latency", (ocyc - e.in_cyc) == e.lat, ocyc - e.in_cyc, e.lat);
        if (e.consec) check("consecutive", ocyc == last_out + 1, ocyc - last_out, 1);
      end
      last_out = ocyc;
    end
  end

  task automatic send(input bit mode, input int x, input int y, input int z,
                      input logic [TAG_W-1:0] tag, input int ex, input int ey,
                      input int ez, input int lat, input bit consec);
    exp_t e;
    int   n;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_x     = W'(x);
    bus.in_y     = W'(y);
    bus.in_z     = W'(z);
    bus.in_tag   = tag;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 1'b0, 0, 1);
    end else begin
      e.mode   = mode;
      e.tag    = tag;
      e.ex     = ex;
      e.ey     = ey;
      e.ez     = ez;
      e.lat    = lat;
      e.consec = consec;
      e.in_cyc = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_vec(input bit mode, input int idx, input logic [TAG_W-1:0] tag,
                          input int lat, input bit consec);
    if (!mode) send(1'b0, 9949, 0, rot_z[idx], tag, rot_ex[idx], rot_ey[idx], 0, lat, consec);
    else       send(1'b1, vec_x[idx], vec_y[idx], 0, tag, 8234, 0, vec_ez[idx], lat, consec);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size() == 0, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic signed [W+1:0] hx;
    logic [TAG_W-1:0]    ht;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_z      = '0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid == 1'b0, int'(bus.out_valid), 0);
    check("rst_out_x", bus.out_x == '0, int'(bus.out_x), 0);
    check("rst_out_tag", bus.out_tag == '0, int'(bus.out_tag), 0);
    check("rst_in_ready", bus.in_ready == 1'b1, int'(bus.in_ready), 1);
    rst = 1'b0;

    // Rotation by pi/4, then the full-range cases -pi and 3pi/4
    send_vec(1'b0, 0, 4'd1, LAT, 1'b0);
    drain();
    send_vec(1'b0, 1, 4'd2, LAT, 1'b0);
    send_vec(1'b0, 2, 4'd3, 0, 1'b1);
    drain();

    // Vectoring in all four quadrants
    for (int i = 0; i < 4; i++) send_vec(1'b1, i, TAG_W'(i + 4), 0, 1'b0);
    drain();

    // Mixed-mode stream with a 5-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 20; i++) send_vec(1'(i % 2), (i / 2) % 4, TAG_W'(i % 16), 0, 1'b0);
      end
      begin
        repeat (22) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        hx = bus.out_x;
        ht = bus.out_tag;
        for (int i = 0; i < 5; i++) begin
          @(negedge clk);
          check("stall_in_ready", bus.in_ready == 1'b0, int'(bus.in_ready), 0);
          check("stall_hold", bus.out_valid && bus.out_x == hx && bus.out_tag == ht,
                int'(bus.out_x), int'(hx));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // 32 back-to-back samples: full throughput once the pipe fills
    for (int i = 0; i < 32; i++)
      send_vec(1'(i % 2), i % 4, TAG_W'(i % 16), (i == 0) ? LAT : 0, i > 0);
    drain();

    // Reset with 10 samples in flight: all dropped, pipeline restarts cleanly
    for (int i = 0; i < 10; i++) send_vec(1'b1, i % 4, TAG_W'(i + 1), 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
    check("postrst_out_valid", bus.out_valid == 1'b0, int'(bus.out_valid), 0);
    check("postrst_out_y", bus.out_y == '0, int'(bus.out_y), 0);
    check("postrst_out_z", bus.out_z == '0, int'(bus.out_z), 0);
    check("postrst_out_mode", bus.out_mode == 1'b0, int'(bus.out_mode), 0);
    check("postrst_out_tag", bus.out_tag == '0, int'(bus.out_tag), 0);
    repeat (25) @(posedge clk);
    #1;
    send_vec(1'b0, 0, 4'd9, LAT, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
